step_pattern_gen: RTL and testbench

STEP_PATTERN_GEN -- requirements
Module: step_pattern_gen

---
 rtl/step_pattern_gen_if.sv | 29 ++
 rtl/step_pattern_gen.sv | 181 ++++++++++++++++++
 tb/tb_step_pattern_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/step_pattern_gen_if.sv
// Bundles the burst request, stall control and the pattern/status outputs
// of step_pattern_gen. The generator uses the slave side and the driver
// (bench or surrounding logic) uses the master side.
interface step_pattern_gen_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic [CNT_W-1:0] idle_cycles;
  logic             hold;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             e;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;

  modport master (
    output start, repeat_cnt, idle_cycles, hold,
    input  a, b, c, d, e, busy, done, pass_cnt
  );

  modport slave (
    input  start, repeat_cnt, idle_cycles, hold,
    output a, b, c, d, e, busy, done, pass_cnt
  );
endinterface

// File: rtl/step_pattern_gen.sv
// Thermometer step pattern generator. One accepted start runs a burst of
// repeat_cnt passes of five steps (a, ab, abc, abcd, abcde), optionally
// framed by idle_cycles all-zero cycles before and after, and finishes
// with a one-cycle done pulse. hold stalls the pattern while stepping.
// All outputs come straight from registers. Each register is loaded on the
// same edge that enters a state, so a state's outputs appear in its first
// cycle.
module step_pattern_gen #(
  parameter int CNT_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  step_pattern_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_STEP  = 3'd2,
    S_TRAIL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_step;
  logic [2:0]       w_step_nxt;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] w_pass_nxt;
  logic [CNT_W-1:0] w_pass_inc;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] w_rep_nxt;
  logic [CNT_W-1:0] r_idle;
  logic [CNT_W-1:0] w_idle_nxt;
  logic [CNT_W-1:0] r_wait;
  logic [CNT_W-1:0] w_wait_nxt;
  logic [4:0]       r_pat;
  logic [4:0]       w_pat_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // Step k lights bits a..(k-th bit); bit 0 is a.
  function automatic logic [4:0] f_therm(input logic [2:0] k);
    logic [4:0] v;
    case (k)
      3'd1:    v = 5'b00001;
      3'd2:    v = 5'b00011;
      3'd3:    v = 5'b00111;
      3'd4:    v = 5'b01111;
      3'd5:    v = 5'b11111;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  // A pass only completes when pass_cnt < latched repeat count, so this cannot wrap.
  assign w_pass_inc = r_pass + CNT_ONE;

  // Next-state and next-value logic for every register in the block.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_pass_nxt  = r_pass;
    w_rep_nxt   = r_rep;
    w_idle_nxt  = r_idle;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_rep_nxt  = bus.repeat_cnt;
          w_idle_nxt = bus.idle_cycles;
          w_pass_nxt = CNT_ZERO;
          w_step_nxt = 3'd0;
          if (bus.repeat_cnt == CNT_ZERO) begin
            w_state_nxt = S_DONE;
          end else if (bus.idle_cycles != CNT_ZERO) begin
            w_state_nxt = S_LEAD;
            w_wait_nxt  = bus.idle_cycles - CNT_ONE;
          end else begin
            w_state_nxt = S_STEP;
            w_step_nxt  = 3'd1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LEAD: begin
        if (r_wait == CNT_ZERO) begin
          w_state_nxt = S_STEP;
          w_step_nxt  = 3'd1;
        end else begin
          w_wait_nxt = r_wait - CNT_ONE;
        end
      end
      S_STEP: begin
        if (bus.hold) begin
          w_step_nxt = r_step;
        end else if (r_step == 3'd5) begin
          w_pass_nxt = w_pass_inc;
          if (w_pass_inc == r_rep) begin
            w_step_nxt = 3'd0;
            if (r_idle != CNT_ZERO) begin
              w_state_nxt = S_TRAIL;
              w_wait_nxt  = r_idle - CNT_ONE;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_step_nxt = 3'd1;
          end
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      S_TRAIL: begin
        if (r_wait == CNT_ZERO) begin
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait - CNT_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = 3'd0;
      end
    endcase
    w_pat_nxt  = (w_state_nxt == S_STEP) ? f_therm(w_step_nxt) : 5'b00000;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, latched burst parameters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step <= 3'd0;
      r_pass <= CNT_ZERO;
      r_rep  <= CNT_ZERO;
      r_idle <= CNT_ZERO;
      r_wait <= CNT_ZERO;
      r_pat  <= 5'b00000;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      r_pass <= w_pass_nxt;
      r_rep  <= w_rep_nxt;
      r_idle <= w_idle_nxt;
      r_wait <= w_wait_nxt;
      r_pat  <= w_pat_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.a        = r_pat[0];
  assign bus.b        = r_pat[1];
  assign bus.c        = r_pat[2];
  assign bus.d        = r_pat[3];
  assign bus.e        = r_pat[4];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass_cnt = r_pass;

endmodule

// File: tb/tb_step_pattern_gen.sv
// Bench for step_pattern_gen: directed scenarios with hand-computed totals,
// then randomized traffic. A queue model expands each accepted burst into the
// list of per-cycle outputs it must produce; hold re-presents a step entry.
module tb_step_pattern_gen;
  localparam int CNT_W = 4;

  logic clock = 1'b0;
  logic reset;

  step_pattern_gen_if #(.CNT_W(CNT_W)) bus ();

  step_pattern_gen #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]       pat;
    logic [CNT_W-1:0] pass;
    logic             is_step;
    logic             is_done;
  } entry_t;

  entry_t           exp_q[$];
  logic [CNT_W-1:0] idle_pass = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_busy, cnt_done, cnt_step, cnt_abc, cnt_idle;

  // Expand one accepted burst into its exact cycle-by-cycle output list.
  task automatic build_burst(input logic [CNT_W-1:0] rep, input logic [CNT_W-1:0] idl);
    entry_t en;
    if (rep != '0) begin
      for (int i = 0; i < int'(idl); i++) begin
        en = '{pat: 5'b0, pass: '0, is_step: 1'b0, is_done: 1'b0};
        exp_q.push_back(en);
      end
      for (int p = 0; p < int'(rep); p++) begin
        for (int k = 1; k <= 5; k++) begin
          en.pat     = 5'((6'd1 << k) - 6'd1);
          en.pass    = CNT_W'(p);
          en.is_step = 1'b1;
          en.is_done = 1'b0;
          exp_q.push_back(en);
        end
      end
      for (int i = 0; i < int'(idl); i++) begin
        en = '{pat: 5'b0, pass: rep, is_step: 1'b0, is_done: 1'b0};
        exp_q.push_back(en);
      end
    end
    en = '{pat: 5'b0, pass: rep, is_step: 1'b0, is_done: 1'b1};
    exp_q.push_back(en);
    idle_pass = rep;
  endtask

  // Reference model: advances one cycle per clock edge.
  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
      idle_pass = '0;
    end else if (exp_q.size() != 0) begin
      if (!(exp_q[0].is_step && bus.hold)) void'(exp_q.pop_front());
    end else if (bus.start) begin
      build_burst(bus.repeat_cnt, bus.idle_cycles);
    end
  end

  task automatic check_now();
    logic [CNT_W+6:0] exp_v, act_v;
    if (exp_q.size() != 0)
      exp_v = {exp_q[0].pat, 1'b1, exp_q[0].is_done, exp_q[0].pass};
    else
      exp_v = {5'b0, 1'b0, 1'b0, idle_pass};
    act_v = {bus.e, bus.d, bus.c, bus.b, bus.a, bus.busy, bus.done, bus.pass_cnt};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL cycle_compare t=%0t actual pat/busy/done/pass=%b required=%b", $time, act_v, exp_v);
    end
    if (bus.busy === 1'b1) cnt_busy++;
    else cnt_idle++;
    if (bus.done === 1'b1) cnt_done++;
    if ({bus.e, bus.d, bus.c, bus.b, bus.a} != 5'b0) cnt_step++;
    if ({bus.e, bus.d, bus.c, bus.b, bus.a} == 5'b00111) cnt_abc++;
  endtask

  task automatic tick();
    @(negedge clock);
    check_now();
  endtask

  task automatic expect_eq(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_tallies();
    cnt_busy = 0; cnt_done = 0; cnt_step = 0; cnt_abc = 0; cnt_idle = 0;
  endtask

  // Start one burst at the current negedge and run until done is seen.
  // holds > 0 stalls the first abc step of pass 0 for that many cycles.
  task automatic run_burst(input int rep, input int idl, input int holds);
    bit finished = 1'b0;
    int hl = holds;
    clear_tallies();
    bus.start       = 1'b1;
    bus.repeat_cnt  = CNT_W'(rep);
    bus.idle_cycles = CNT_W'(idl);
    bus.hold        = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      bus.start       = 1'b0;
      bus.repeat_cnt  = CNT_W'($urandom_range(0, 15));
      bus.idle_cycles = CNT_W'($urandom_range(0, 15));
      bus.hold        = 1'b0;
      if (hl > 0 && exp_q.size() != 0 && exp_q[0].pat == 5'b00111 && exp_q[0].pass == '0) begin
        bus.hold = 1'b1;
        hl--;
      end
      if (bus.done === 1'b1) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) expect_eq("burst_timeout", 0, 1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.repeat_cnt  = '0;
    bus.idle_cycles = '0;
    bus.hold        = 1'b0;
    clear_tallies();
    repeat (2) @(negedge clock);
    expect_eq("reset_pattern", int'({bus.e, bus.d, bus.c, bus.b, bus.a}), 0);
    expect_eq("reset_busy", int'(bus.busy), 0);
    expect_eq("reset_done", int'(bus.done), 0);
    expect_eq("reset_pass", int'(bus.pass_cnt), 0);
    reset = 1'b0;

    // Five passes, no idle framing.
    run_burst(5, 0, 0);
    expect_eq("s1_busy", cnt_busy, 26);
    expect_eq("s1_done", cnt_done, 1);
    expect_eq("s1_step", cnt_step, 25);
    expect_eq("s1_abc", cnt_abc, 5);
    expect_eq("s1_pass", int'(bus.pass_cnt), 5);
    tick();
    expect_eq("s1_pass_hold", int'(bus.pass_cnt), 5);

    // One pass framed by three zero cycles each side.
    run_burst(1, 3, 0);
    expect_eq("s2_busy", cnt_busy, 12);
    expect_eq("s2_step", cnt_step, 5);
    expect_eq("s2_done", cnt_done, 1);
    tick();

    // Two passes, abc of pass 0 stalled four cycles.
    run_burst(2, 0, 4);
    expect_eq("s3_step", cnt_step, 14);
    expect_eq("s3_abc", cnt_abc, 6);
    expect_eq("s3_pass", int'(bus.pass_cnt), 2);
    tick();

    // Zero passes: only a done cycle.
    run_burst(0, 5, 0);
    expect_eq("s4_busy", cnt_busy, 1);
    expect_eq("s4_done", cnt_done, 1);
    expect_eq("s4_step", cnt_step, 0);
    expect_eq("s4_pass", int'(bus.pass_cnt), 0);
    tick();

    // Reset at step 4 of pass 2 of 3.
    clear_tallies();
    bus.start = 1'b1; bus.repeat_cnt = 4'd3; bus.idle_cycles = 4'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      bus.start = 1'b0;
      if (exp_q.size() != 0 && exp_q[0].pat == 5'b01111 && exp_q[0].pass == 4'd1) break;
    end
    expect_eq("s5_reached_step4", int'({bus.e, bus.d, bus.c, bus.b, bus.a}), 15);
    reset = 1'b1;
    #1;
    expect_eq("s5_async_pattern", int'({bus.e, bus.d, bus.c, bus.b, bus.a}), 0);
    expect_eq("s5_async_busy", int'(bus.busy), 0);
    expect_eq("s5_async_pass", int'(bus.pass_cnt), 0);
    tick();
    reset = 1'b0;
    clear_tallies();
    repeat (10) tick();
    expect_eq("s5_no_done", cnt_done, 0);
    run_burst(3, 0, 0);
    expect_eq("s5_rerun_busy", cnt_busy, 16);
    expect_eq("s5_rerun_pass", int'(bus.pass_cnt), 3);
    tick();

    // Start held high: back-to-back bursts, one idle cycle between.
    clear_tallies();
    bus.start = 1'b1; bus.repeat_cnt = 4'd1; bus.idle_cycles = 4'd0;
    repeat (21) tick();
    expect_eq("s6_busy", cnt_busy, 18);
    expect_eq("s6_done", cnt_done, 3);
    expect_eq("s6_idle", cnt_idle, 3);
    bus.start = 1'b0;
    repeat (8) tick();

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.repeat_cnt  = CNT_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      bus.idle_cycles = CNT_W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
      bus.hold        = ($urandom_range(0, 3) == 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
